// File: rtl/systolic_load_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_load_if
// Description : Row stream, memA write port, memB step port and status
//               signals of the systolic load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_load_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  logic                              start;
  logic                              in_valid;
  logic                              in_ready;
  logic [DIM-1:0][BITS_AB-1:0]       in_data;
  logic                              A_WrEn;
  logic [$clog2(DIM)-1:0]            A_row;
  logic [DIM-1:0][BITS_AB-1:0]       A_data;
  logic                              step_en;
  logic [DIM-1:0][BITS_AB-1:0]       B_data;
  logic                              busy;
  logic                              done;

  // Sequencer side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, A_WrEn, A_row, A_data, step_en, B_data, busy, done
  );

  // Row source / consumer side
  modport master (
    output start, in_valid, in_data,
    input  in_ready, A_WrEn, A_row, A_data, step_en, B_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_load_ctrl
// Description : Loads DIM rows of A into memA, streams DIM rows of B into the
//               memB skew pipeline, then issues 2*DIM-1 zero flush steps and
//               pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_load_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic           clk,
  input  logic           rst,
  systolic_load_if.slave bus
);

  localparam int c_ROW_W = $clog2(DIM);
  localparam int c_CNT_W = c_ROW_W + 1;
  localparam logic [c_CNT_W-1:0] c_ROW_LAST  = c_CNT_W'(DIM - 1);
  // FLUSH counts 0..2*DIM-2 while stepping; the value 2*DIM-1 marks completion
  localparam logic [c_CNT_W-1:0] c_FLUSH_END = c_CNT_W'(2 * DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_A = 2'd1,
    S_LOAD_B = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [c_CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                        r_a_wr_en, w_a_wr_en_nxt;
  logic [c_ROW_W-1:0]          r_a_row, w_a_row_nxt;
  logic [DIM-1:0][BITS_AB-1:0] r_a_data, w_a_data_nxt;
  logic                        r_step_en, w_step_en_nxt;
  logic [DIM-1:0][BITS_AB-1:0] r_b_data, w_b_data_nxt;
  logic                        r_busy, w_busy_nxt;
  logic                        r_done, w_done_nxt;
  logic                        w_in_ready;
  logic                        w_accept;

  // Ready is a pure decode of the registered state so it drops with async reset
  assign w_in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;
  assign bus.A_WrEn   = r_a_wr_en;
  assign bus.A_row    = r_a_row;
  assign bus.A_data   = r_a_data;
  assign bus.step_en  = r_step_en;
  assign bus.B_data   = r_b_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_a_wr_en <= 1'b0;
      r_a_row   <= '0;
      r_a_data  <= '0;
      r_step_en <= 1'b0;
      r_b_data  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_a_wr_en <= w_a_wr_en_nxt;
      r_a_row   <= w_a_row_nxt;
      r_a_data  <= w_a_data_nxt;
      r_step_en <= w_step_en_nxt;
      r_b_data  <= w_b_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next state and next output values; strobes default low, data holds
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_a_wr_en_nxt = 1'b0;
    w_a_row_nxt   = r_a_row;
    w_a_data_nxt  = r_a_data;
    w_step_en_nxt = 1'b0;
    w_b_data_nxt  = r_b_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD_A;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_LOAD_A: begin
        if (w_accept) begin
          w_a_wr_en_nxt = 1'b1;
          w_a_row_nxt   = r_cnt[c_ROW_W-1:0];
          w_a_data_nxt  = bus.in_data;
          if (r_cnt == c_ROW_LAST) begin
            w_state_nxt = S_LOAD_B;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        // A stall leaves step_en low so memA and memB freeze together
        if (w_accept) begin
          w_step_en_nxt = 1'b1;
          w_b_data_nxt  = bus.in_data;
          if (r_cnt == c_ROW_LAST) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (r_cnt == c_FLUSH_END) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_step_en_nxt = 1'b1;
          w_b_data_nxt  = '0;
          w_cnt_nxt     = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_load_ctrl
// Description : Scoreboard bench for systolic_load_ctrl. The driver queues the
//               expected memA writes, memB steps and done cycle; a monitor
//               pops and compares whenever the DUT strobes an output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_load_ctrl;

  localparam int DIM  = 8;
  localparam int BITS = 8;

  typedef logic [DIM*BITS-1:0] row_t;
  typedef struct {
    int   row;
    row_t data;
  } a_item_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      cyc = 0;
  int      n_cmp = 0;
  int      n_err = 0;
  a_item_t a_q[$];
  row_t    b_q[$];
  int      d_q[$];
  a_item_t mon_a;
  row_t    mon_b;
  int      mon_d;

  systolic_load_if #(.BITS_AB(BITS), .DIM(DIM)) bus ();

  systolic_load_ctrl #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp start and done
  always @(posedge clk) cyc <= cyc + 1;

  function automatic row_t row_a(input int r);
    row_t v;
    for (int c = 0; c < DIM; c++) v[c*BITS +: BITS] = 8'(r * DIM + c);
    return v;
  endfunction

  function automatic row_t row_b(input int r);
    row_t v;
    for (int c = 0; c < DIM; c++) v[c*BITS +: BITS] = 8'(-(r * DIM + c));
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen/timeout, required none (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every output strobe against the scoreboard queues
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.A_WrEn && bus.step_en) flag("A_WrEn_and_step_en_overlap");
      if (bus.A_WrEn) begin
        if (a_q.size() == 0) flag("A_WrEn_unexpected");
        else begin
          mon_a = a_q.pop_front();
          chk("A_row", 64'(bus.A_row), 64'(mon_a.row));
          chk("A_data", bus.A_data, mon_a.data);
        end
      end
      if (bus.step_en) begin
        if (b_q.size() == 0) flag("step_en_unexpected");
        else begin
          mon_b = b_q.pop_front();
          chk("B_data", bus.B_data, mon_b);
        end
      end
      if (bus.done) begin
        if (d_q.size() == 0) flag("done_unexpected");
        else begin
          mon_d = d_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_d));
          chk("busy_low_at_done", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  // One full sequence; sa/sb are stall cycles after A row 3 / B row 5,
  // hold keeps start high throughout, abort resets after 4 B rows
  task automatic run_seq(input int sa, input int sb, input bit hold, input bit abort);
    int   s;
    int   guard;
    int   n;
    row_t d;
    for (int r = 0; r < DIM; r++) a_q.push_back('{r, row_a(r)});
    for (int r = 0; r < DIM; r++) b_q.push_back(row_b(r));
    for (int r = 0; r < 2*DIM-1; r++) b_q.push_back('0);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = row_a(0);
    @(posedge clk);
    #1 s = cyc;
    d_q.push_back(s + 4*DIM + sa + sb);
    @(negedge clk);
    bus.start = hold;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 2*DIM; i++) begin
      d = (i < DIM) ? row_a(i) : row_b(i - DIM);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        flag("in_ready_timeout");
        return;
      end
      @(negedge clk);
      if (abort && i == DIM + 3) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_step_en", 64'(bus.step_en), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_B_data", bus.B_data, 64'd0);
        chk("rst_A_data", bus.A_data, 64'd0);
        a_q.delete();
        b_q.delete();
        d_q.delete();
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        return;
      end
      n = (i == 3) ? sa : ((i == DIM + 5) ? sb : 0);
      if (n > 0) begin
        bus.in_valid = 1'b0;
        repeat (n) begin
          @(negedge clk);
          if (i < DIM) chk("A_WrEn_stall_gap", 64'(bus.A_WrEn), 64'd0);
          else begin
            chk("step_en_stall_gap", 64'(bus.step_en), 64'd0);
            chk("B_data_held", bus.B_data, row_b(5));
          end
        end
      end
    end
    // Junk row offered during FLUSH must never be accepted
    bus.in_valid = 1'b1;
    bus.in_data  = {DIM{8'h5A}};
    guard = 0;
    while (!bus.done && guard < 4*DIM) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.done) flag("done_timeout");
    chk("a_queue_drained", 64'(a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_q.size()), 64'd0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.B_data ^ bus.A_data}, 64'd0);
    chk("reset_strobes", 64'({bus.in_ready, bus.A_WrEn, bus.step_en, bus.busy, bus.done, bus.A_row}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // in_valid in IDLE is ignored
    bus.in_valid = 1'b1;
    bus.in_data  = row_a(1);
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid_in_ready", 64'(bus.in_ready), 64'd0);
      chk("idle_valid_no_write", 64'({bus.A_WrEn, bus.step_en}), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    run_seq(0, 0, 1'b0, 1'b0);   // no stalls
    @(negedge clk);
    run_seq(1, 2, 1'b0, 1'b0);   // input stalls
    @(negedge clk);
    run_seq(0, 0, 1'b0, 1'b1);   // reset during LOAD_B
    run_seq(0, 0, 1'b0, 1'b0);   // full replay after reset
    @(negedge clk);
    run_seq(0, 0, 1'b1, 1'b0);   // start held through the run and across done
    run_seq(0, 0, 1'b0, 1'b0);   // back-to-back second run
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_queue_drained", 64'(d_q.size()), 64'd0);
    chk("final_idle_busy", 64'(bus.busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
